// File: rtl/nes_cpu_pkg.sv
// rtl/nes_cpu_pkg.sv - shared 2A03 core constants: P flag indices, flag_op codes, reset P
package nes_cpu_pkg;

    // Bit positions inside the processor status byte
    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    // Flag instruction encodings carried on flag_op
    typedef enum logic [2:0] {
        FOP_NOP = 3'd0,
        FOP_SEC = 3'd1,
        FOP_CLC = 3'd2,
        FOP_SEI = 3'd3,
        FOP_CLI = 3'd4,
        FOP_CLV = 3'd5,
        FOP_SED = 3'd6,
        FOP_CLD = 3'd7
    } fop_e;

    // Which flags an ALU op is allowed to touch when it retires
    typedef struct packed {
        logic nz;
        logic c;
        logic v;
    } wb_mask_t;

    // I set, unused bits 5/4 read as 1, everything else clear
    localparam logic [7:0] P_RESET = 8'h34;

endpackage

// File: rtl/status_flags_if.sv
// rtl/status_flags_if.sv - CPU-core side bundle of the status register unit
interface status_flags_if;
    logic       issue_valid;
    logic       upd_nz;
    logic       upd_c;
    logic       upd_v;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;
    logic [2:0] flag_op;
    logic       plp_valid;
    logic [7:0] plp_data;
    logic       instr_boundary;
    logic       push_b;
    logic [7:0] p_out;
    logic [7:0] push_byte;
    logic       irq_inhibit;
    logic       wb_pending;

    modport master (
        output issue_valid, upd_nz, upd_c, upd_v,
        output alu_result, alu_carry, alu_overflow,
        output flag_op, plp_valid, plp_data, instr_boundary, push_b,
        input  p_out, push_byte, irq_inhibit, wb_pending
    );

    modport slave (
        input  issue_valid, upd_nz, upd_c, upd_v,
        input  alu_result, alu_carry, alu_overflow,
        input  flag_op, plp_valid, plp_data, instr_boundary, push_b,
        output p_out, push_byte, irq_inhibit, wb_pending
    );
endinterface

// File: rtl/status_wb_stage.sv
// rtl/status_wb_stage.sv - one-deep ALU flag writeback pipeline and N/Z/C/V next values
module status_wb_stage
    import nes_cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid,
    input  wb_mask_t   issue_mask,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic [7:0] p_cur,
    output logic       wb_pending,
    output logic [7:0] p_wb
);

    wb_mask_t mask_q;

    // Capture the issued op's mask; it retires on the very next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q     <= '0;
            wb_pending <= 1'b0;
        end else begin
            wb_pending <= issue_valid;
            mask_q     <= issue_valid ? issue_mask : '0;
        end
    end

    // Apply the retiring op's masked flag updates on top of the current P
    always_comb begin
        p_wb = p_cur;
        if (wb_pending) begin
            if (mask_q.nz) begin
                p_wb[P_N] = alu_result[7];
                p_wb[P_Z] = (alu_result == 8'h00);
            end
            if (mask_q.c) begin
                p_wb[P_C] = alu_carry;
            end
            if (mask_q.v) begin
                p_wb[P_V] = alu_overflow;
            end
        end
    end

endmodule

// File: rtl/status_flags.sv
// rtl/status_flags.sv - 2A03 P register; STATUS_IRQ_DELAY_EN adds one-instruction IRQ-inhibit latency
module status_flags
    import nes_cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    status_flags_if.slave bus
);

    logic [7:0] p_q;
    logic [7:0] p_wb;
    logic [7:0] p_nxt;
    wb_mask_t   issue_mask;

    assign issue_mask = '{nz: bus.upd_nz, c: bus.upd_c, v: bus.upd_v};

    status_wb_stage u_wb (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (bus.issue_valid),
        .issue_mask   (issue_mask),
        .alu_result   (bus.alu_result),
        .alu_carry    (bus.alu_carry),
        .alu_overflow (bus.alu_overflow),
        .p_cur        (p_q),
        .wb_pending   (bus.wb_pending),
        .p_wb         (p_wb)
    );

    // Per-bit priority: pulled byte over flag instruction over ALU writeback
    always_comb begin
        p_nxt = p_wb;
        case (fop_e'(bus.flag_op))
            FOP_SEC: p_nxt[P_C] = 1'b1;
            FOP_CLC: p_nxt[P_C] = 1'b0;
            FOP_SEI: p_nxt[P_I] = 1'b1;
            FOP_CLI: p_nxt[P_I] = 1'b0;
            FOP_CLV: p_nxt[P_V] = 1'b0;
            FOP_SED: p_nxt[P_D] = 1'b1;
            FOP_CLD: p_nxt[P_D] = 1'b0;
            default: ;
        endcase
        if (bus.plp_valid) begin
            p_nxt = bus.plp_data;
        end
        // Bits 5/4 are not real flags; pinning them makes those flops constant
        p_nxt[P_U] = 1'b1;
        p_nxt[P_B] = 1'b1;
    end

    // P storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= P_RESET;
        end else begin
            p_q <= p_nxt;
        end
    end

    assign bus.p_out     = p_q;
    assign bus.push_byte = (p_q & ~8'h10) | {3'b000, bus.push_b, 4'b0000};

`ifdef STATUS_IRQ_DELAY_EN
    logic i_eff;

    // Poller sees the I value that held before the instruction boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_eff <= 1'b1;
        end else if (bus.instr_boundary) begin
            i_eff <= p_q[P_I];
        end
    end

    assign bus.irq_inhibit = i_eff;
`else
    assign bus.irq_inhibit = p_q[P_I];
`endif

endmodule

// File: tb/tb_status_flags.sv
// tb/tb_status_flags.sv - randomized bench for status_flags against a byte-level model
module tb_status_flags;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    status_flags_if bus ();

    status_flags dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: P as the full byte, the pending retire, the IRQ level
    logic [7:0] m_p;
    logic       m_pend;
    logic [2:0] m_mask;
    logic       m_ieff;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        m_p    = 8'h34;
        m_pend = 1'b0;
        m_mask = 3'b000;
        m_ieff = 1'b1;
    endtask

    function automatic logic m_irq();
`ifdef STATUS_IRQ_DELAY_EN
        return m_ieff;
`else
        return m_p[2];
`endif
    endfunction

    task automatic mdl_edge();
        logic [7:0] np;
        np = m_p;
        if (m_pend) begin
            if (m_mask[2]) begin
                np[7] = bus.alu_result[7];
                np[1] = (bus.alu_result == 0);
            end
            if (m_mask[1]) np[0] = bus.alu_carry;
            if (m_mask[0]) np[6] = bus.alu_overflow;
        end
        case (bus.flag_op)
            3'd1: np = np | 8'h01;
            3'd2: np = np & 8'hFE;
            3'd3: np = np | 8'h04;
            3'd4: np = np & 8'hFB;
            3'd5: np = np & 8'hBF;
            3'd6: np = np | 8'h08;
            3'd7: np = np & 8'hF7;
            default: ;
        endcase
        if (bus.plp_valid) np = bus.plp_data | 8'h30;
        if (bus.instr_boundary) m_ieff = m_p[2];
        m_p    = np;
        m_pend = bus.issue_valid;
        m_mask = {bus.upd_nz, bus.upd_c, bus.upd_v};
    endtask

    task automatic check_all();
        chk("p_out", bus.p_out, m_p);
        chk("push_byte", bus.push_byte, (m_p & 8'hEF) | (8'(bus.push_b) << 4));
        chk("irq_inhibit", {7'd0, bus.irq_inhibit}, {7'd0, m_irq()});
        chk("wb_pending", {7'd0, bus.wb_pending}, {7'd0, m_pend});
    endtask

    task automatic idle();
        bus.issue_valid    = 1'b0;
        bus.upd_nz         = 1'b0;
        bus.upd_c          = 1'b0;
        bus.upd_v          = 1'b0;
        bus.alu_result     = 8'h00;
        bus.alu_carry      = 1'b0;
        bus.alu_overflow   = 1'b0;
        bus.flag_op        = 3'd0;
        bus.plp_valid      = 1'b0;
        bus.plp_data       = 8'h00;
        bus.instr_boundary = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mdl_reset();
        #1;
        chk("rst_p_out", bus.p_out, 8'h34);
        chk("rst_irq", {7'd0, bus.irq_inhibit}, 8'h01);
        chk("rst_wbp", {7'd0, bus.wb_pending}, 8'h00);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        bus.push_b = 1'b1;
        rst_n = 1'b1;
        #2;
        do_reset();
        chk("rst_push", bus.push_byte, 8'h34);

        // All three flags from one op: zero result, carry and overflow
        bus.issue_valid = 1; bus.upd_nz = 1; bus.upd_c = 1; bus.upd_v = 1;
        tick();
        idle();
        bus.alu_result = 8'h00; bus.alu_carry = 1; bus.alu_overflow = 1;
        tick();
        chk("all_upd", bus.p_out, 8'h77);

        // Back-to-back: {nz} with 80, then {c} with carry 0
        idle();
        bus.issue_valid = 1; bus.upd_nz = 1;
        tick();
        bus.upd_nz = 0; bus.upd_c = 1; bus.alu_result = 8'h80;
        tick();
        chk("b2b_n", {7'd0, bus.p_out[7]}, 8'h01);
        idle();
        bus.alu_carry = 0;
        tick();
        chk("b2b_c", {7'd0, bus.p_out[0]}, 8'h00);
        chk("b2b_n_hold", {7'd0, bus.p_out[7]}, 8'h01);

        // Same-edge collision: writeback V, CLV and PLP together
        bus.issue_valid = 1; bus.upd_v = 1;
        tick();
        idle();
        bus.alu_overflow = 1; bus.flag_op = 3'd5; bus.plp_valid = 1; bus.plp_data = 8'hC3;
        tick();
        chk("plp_wins", bus.p_out, 8'hF3);

        // CLI right after reset, then observe the inhibit level
        idle();
        do_reset();
        bus.flag_op = 3'd4;
        tick();
        chk("cli_i", {7'd0, bus.p_out[2]}, 8'h00);
`ifdef STATUS_IRQ_DELAY_EN
        chk("cli_irq_held", {7'd0, bus.irq_inhibit}, 8'h01);
`else
        chk("cli_irq_now", {7'd0, bus.irq_inhibit}, 8'h00);
`endif
        idle();
        tick();
        tick();
        bus.instr_boundary = 1;
        tick();
        idle();
        chk("cli_irq_after_bnd", {7'd0, bus.irq_inhibit}, 8'h00);

        // Reset landing in the writeback cycle drops the pending update
        bus.issue_valid = 1; bus.upd_nz = 1;
        tick();
        idle();
        bus.alu_result = 8'h80;
        do_reset();
        tick();
        chk("rst_mid_wb", bus.p_out, 8'h34);
        idle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.issue_valid    = $urandom_range(0, 1);
            bus.upd_nz         = $urandom_range(0, 1);
            bus.upd_c          = $urandom_range(0, 1);
            bus.upd_v          = $urandom_range(0, 1);
            bus.alu_result     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            bus.alu_carry      = $urandom_range(0, 1);
            bus.alu_overflow   = $urandom_range(0, 1);
            bus.flag_op        = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
            bus.plp_valid      = ($urandom_range(0, 9) == 0);
            bus.plp_data       = 8'($urandom);
            bus.instr_boundary = ($urandom_range(0, 3) == 0);
            bus.push_b         = $urandom_range(0, 1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
